// File: rtl/avmm_pkg.sv
// avmm_pkg -- shared types and constants for the avmm_burst_mem slice.
//
// Contents:
//   state_t           command FSM states (IDLE / RD / WR)
//   AVMM_*            default widths and read latency used as parameter defaults
//   LFSR_SEED/TAPS    wait-injection LFSR constants (16-bit Fibonacci, taps 16,14,13,11)
//   lfsr_next()       one LFSR step
package avmm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } state_t;

   localparam int AVMM_ADDR_W       = 24;
   localparam int AVMM_DATA_W       = 32;
   localparam int AVMM_BURST_W      = 4;
   localparam int AVMM_MEM_AW       = 14;
   localparam int AVMM_READ_LATENCY = 2;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Taps 16,14,13,11 expressed as a mask over bits [15:0].
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] i_state);
      return {i_state[14:0], ^(i_state & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/avmm_mem_sram.sv
// avmm_mem_sram -- single-port synchronous RAM with per-byte write enables.
//
// Ports:
//   clk      in   clock
//   rst_n    in   async active-low reset (read-data register only)
//   i_we     in   write enable, byte-masked by i_be
//   i_re     in   read enable; data appears on o_rdata the next cycle and holds
//   i_addr   in   word index
//   i_be     in   byte enables for writes
//   i_wdata  in   write data
//   o_rdata  out  registered read data
module avmm_mem_sram
   import avmm_pkg::*;
#(
   parameter int AW = AVMM_MEM_AW,
   parameter int DW = AVMM_DATA_W
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_we,
   input  logic            i_re,
   input  logic [AW-1:0]   i_addr,
   input  logic [DW/8-1:0] i_be,
   input  logic [DW-1:0]   i_wdata,
   output logic [DW-1:0]   o_rdata
);

   logic [DW-1:0] r_mem [2**AW];
   logic [DW-1:0] r_rdata;

   // NOTE: the array has no reset branch; a reset would turn it into flops
   // and its contents must survive rst_n anyway.
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < DW/8; b++) begin
            if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/avmm_burst_mem.sv
// avmm_burst_mem -- Avalon-MM burst slave backed by a byte-enabled on-chip RAM.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   s_address           word address, sampled only when a command is accepted
//   s_read / s_write    read command / write command or write beat
//   s_writedata         write data
//   s_byteenable        per-byte write enable
//   s_burstcount        beats in the burst (0 is treated as 1 and flagged)
//   s_waitrequest       1 = command/beat not accepted this cycle
//   s_readdata          read beat data
//   s_readdatavalid     read beat valid, READ_LATENCY cycles after the read accept
//   proto_err           one-cycle pulse after a misused command
//
// Build option: define AVMM_MEM_WAIT_INJECT_EN to add a 16-bit LFSR that
// randomly holds s_waitrequest high in IDLE and WR. Without it, s_waitrequest
// depends only on the FSM state.
module avmm_burst_mem
   import avmm_pkg::*;
#(
   parameter int ADDR_W       = AVMM_ADDR_W,
   parameter int DATA_W       = AVMM_DATA_W,
   parameter int BURST_W      = AVMM_BURST_W,
   parameter int MEM_AW       = AVMM_MEM_AW,
   parameter int READ_LATENCY = AVMM_READ_LATENCY
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_W-1:0]     s_address,
   input  logic                  s_read,
   input  logic                  s_write,
   input  logic [DATA_W-1:0]     s_writedata,
   input  logic [DATA_W/8-1:0]   s_byteenable,
   input  logic [BURST_W-1:0]    s_burstcount,
   output logic                  s_waitrequest,
   output logic [DATA_W-1:0]     s_readdata,
   output logic                  s_readdatavalid,
   output logic                  proto_err
);

   state_t                  r_state;
   state_t                  w_next_state;
   logic [MEM_AW-1:0]       r_addr;          // next word index of the active burst
   logic [BURST_W-1:0]      r_remain;        // RAM accesses still to perform
   logic [BURST_W-1:0]      r_rd_left;       // read beats still to deliver
   logic [READ_LATENCY-1:0] r_vld;
   logic                    r_proto_err;

   logic                    w_wait_inject;
   logic                    w_wait;
   logic                    w_free;
   logic [BURST_W-1:0]      w_burst;
   logic                    w_vld_out;
   logic                    w_err;
   logic                    w_ram_we;
   logic                    w_ram_re;
   logic [MEM_AW-1:0]       w_ram_addr;
   logic [DATA_W-1:0]       w_ram_rdata;

   generate
      if (ADDR_W > MEM_AW) begin : g_addr_hi
         // Upper address bits select nothing; the RAM aliases across them.
         logic w_unused_addr_hi;
         assign w_unused_addr_hi = &{1'b0, s_address[ADDR_W-1:MEM_AW]};
      end
   endgenerate

`ifdef AVMM_MEM_WAIT_INJECT_EN
   logic [15:0] r_lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_lfsr <= LFSR_SEED;
      else        r_lfsr <= lfsr_next(r_lfsr);
   end

   assign w_wait_inject = r_lfsr[0];
`else
   assign w_wait_inject = 1'b0;
`endif

   // RD always stalls the bus; the injector only adds stalls in IDLE/WR.
   assign w_wait    = (r_state == RD) | w_wait_inject;
   assign w_free    = ~w_wait;
   assign w_burst   = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;
   assign w_vld_out = r_vld[READ_LATENCY-1];

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE: begin
            // A write wins over a simultaneous read.
            if (w_free & s_write)
               w_next_state = (w_burst == BURST_W'(1)) ? IDLE : WR;
            else if (w_free & s_read)
               w_next_state = RD;
         end
         WR: begin
            if (w_free & s_write & (r_remain == BURST_W'(1)))
               w_next_state = IDLE;
         end
         RD: begin
            // Leave in the cycle that presents the last beat.
            if (w_vld_out & (r_rd_left == BURST_W'(1)))
               w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no branch can
      // leave one unassigned and infer a latch.
      s_waitrequest = w_wait;
      w_ram_we      = 1'b0;
      w_ram_re      = 1'b0;
      w_ram_addr    = r_addr;
      w_err         = 1'b0;
      unique case (r_state)
         IDLE: begin
            // Beat 0 of either command goes straight to the RAM at s_address.
            w_ram_addr = s_address[MEM_AW-1:0];
            if (w_free) begin
               w_ram_we = s_write;
               w_ram_re = s_read & ~s_write;
               w_err    = (s_read & s_write)
                        | ((s_read | s_write) & (s_burstcount == '0));
            end
         end
         WR: begin
            w_ram_we = w_free & s_write;
            w_err    = w_free & s_read;
         end
         RD: begin
            w_ram_re = (r_remain != '0);
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------- burst counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr    <= '0;
         r_remain  <= '0;
         r_rd_left <= '0;
      end else begin
         // Index arithmetic is MEM_AW bits wide, so bursts wrap at the top.
         if (w_ram_we | w_ram_re) begin
            r_addr   <= w_ram_addr + 1'b1;
            r_remain <= (r_state == IDLE) ? (w_burst - 1'b1) : (r_remain - 1'b1);
         end
         if ((r_state == IDLE) & w_ram_re)
            r_rd_left <= w_burst;
         else if (w_vld_out & (r_rd_left != '0))
            r_rd_left <= r_rd_left - 1'b1;
      end
   end

   // ----------------------------------------------------- read valid pipe
   // r_vld[0] lines up with the RAM output register; each extra stage adds a cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= w_ram_re;
         for (int k = 1; k < READ_LATENCY; k++) r_vld[k] <= r_vld[k-1];
      end
   end

   // ------------------------------------------------------ read data pipe
   generate
      if (READ_LATENCY == 1) begin : g_lat1
         assign s_readdata = w_ram_rdata;
      end else begin : g_latn
         logic [DATA_W-1:0] r_dpipe [READ_LATENCY-1];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 0; k < READ_LATENCY-1; k++) r_dpipe[k] <= '0;
            end else begin
               r_dpipe[0] <= w_ram_rdata;
               for (int k = 1; k < READ_LATENCY-1; k++) r_dpipe[k] <= r_dpipe[k-1];
            end
         end

         assign s_readdata = r_dpipe[READ_LATENCY-2];
      end
   endgenerate

   assign s_readdatavalid = w_vld_out;

   // ------------------------------------------------------ protocol error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_proto_err <= 1'b0;
      else        r_proto_err <= w_err;
   end

   assign proto_err = r_proto_err;

   // ------------------------------------------------------------------ RAM
   avmm_mem_sram #(
      .AW (MEM_AW),
      .DW (DATA_W)
   ) u_sram (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_ram_we),
      .i_re    (w_ram_re),
      .i_addr  (w_ram_addr),
      .i_be    (s_byteenable),
      .i_wdata (s_writedata),
      .o_rdata (w_ram_rdata)
   );

endmodule

// File: tb/tb_avmm_burst_mem.sv
// tb_avmm_burst_mem -- self-checking bench for avmm_burst_mem.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_avmm_burst_mem;

   localparam int RL     = 2;
   localparam int RD_WIN = 30;

   logic        clk;
   logic        rst_n;
   logic [23:0] s_address;
   logic        s_read;
   logic        s_write;
   logic [31:0] s_writedata;
   logic [3:0]  s_byteenable;
   logic [3:0]  s_burstcount;
   logic        s_waitrequest;
   logic [31:0] s_readdata;
   logic        s_readdatavalid;
   logic        proto_err;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_perr   = 0;
   logic [31:0] g_wd [16];
   logic [3:0]  g_be [16];
   logic [31:0] g_rd [16];

   typedef struct {
      bit          wr;
      logic [23:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   avmm_burst_mem dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .s_address       (s_address),
      .s_read          (s_read),
      .s_write         (s_write),
      .s_writedata     (s_writedata),
      .s_byteenable    (s_byteenable),
      .s_burstcount    (s_burstcount),
      .s_waitrequest   (s_waitrequest),
      .s_readdata      (s_readdata),
      .s_readdatavalid (s_readdatavalid),
      .proto_err       (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (rst_n && proto_err) n_perr++;

`ifdef AVMM_MEM_WAIT_INJECT_EN
   bit stall_seen = 1'b0;
   bit go_seen    = 1'b0;
   always @(negedge clk) begin
      if (rst_n && s_write) begin
         if (s_waitrequest) stall_seen = 1'b1;
         else               go_seen    = 1'b1;
      end
   end
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      s_read       = 1'b0;
      s_write      = 1'b0;
      s_address    = '0;
      s_writedata  = '0;
      s_byteenable = '0;
      s_burstcount = '0;
   endtask

   // Write burst using g_wd/g_be; later beats drive junk address/burstcount.
   task automatic wr_burst(input logic [23:0] addr, input logic [3:0] n);
      int beats = (n == 4'd0) ? 1 : int'(n);
      int guard;
      for (int i = 0; i < beats; i++) begin
         s_write      = 1'b1;
         s_writedata  = g_wd[i];
         s_byteenable = g_be[i];
         s_address    = (i == 0) ? addr : 24'hFFFFFF;
         s_burstcount = (i == 0) ? n : 4'hF;
         guard = 0;
         while (s_waitrequest && guard < 200) begin
            tick();
            guard++;
         end
         if (guard >= 200) check("wr_stall_timeout", 32'(guard), 32'd0);
         tick();
      end
      idle_inputs();
   endtask

   // Read burst; results in g_rd. Checks latency, beat count, no gaps and
   // the waitrequest release right after the last beat.
   task automatic rd_burst(input logic [23:0] addr, input logic [3:0] n, input string tag);
      int exp_n = (n == 4'd0) ? 1 : int'(n);
      int first = -1;
      int last  = -1;
      int cnt   = 0;
      int gaps  = 0;
      int guard = 0;
      bit wq [RD_WIN+2];
      s_read       = 1'b1;
      s_address    = addr;
      s_burstcount = n;
      while (s_waitrequest && guard < 200) begin
         tick();
         guard++;
      end
      if (guard >= 200) check({tag, " rd_stall_timeout"}, 32'(guard), 32'd0);
      tick();
      idle_inputs();
      for (int k = 1; k <= RD_WIN; k++) begin
         wq[k] = s_waitrequest;
         if (s_readdatavalid) begin
            if (first < 0) first = k;
            else if (last != k - 1) gaps++;
            if (cnt < 16) g_rd[cnt] = s_readdata;
            cnt++;
            last = k;
         end
         tick();
      end
      check({tag, " latency"}, 32'(first), 32'(RL));
      check({tag, " beats"},   32'(cnt),   32'(exp_n));
      check({tag, " gaps"},    32'(gaps),  32'd0);
`ifndef AVMM_MEM_WAIT_INJECT_EN
      if (last > 0 && last < RD_WIN) begin
         check({tag, " wait_on_last"}, 32'(wq[last]),   32'd1);
         check({tag, " wait_after"},   32'(wq[last+1]), 32'd0);
      end
`endif
   endtask

   initial begin
      vec_t vt [14];
      int   cnt;
      int   wcnt;
      int   p0;
      int   guard;

      rst_n = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
`ifndef AVMM_MEM_WAIT_INJECT_EN
      check("reset waitrequest", 32'(s_waitrequest), 32'd0);
`endif
      check("reset readdata",    s_readdata,             32'd0);
      check("reset readvalid",   32'(s_readdatavalid),   32'd0);
      check("reset proto_err",   32'(proto_err),         32'd0);
      rst_n = 1'b1;
      tick();
      tick();

`ifdef AVMM_MEM_WAIT_INJECT_EN
      begin
         logic [31:0] mdl [32];
         int beats = 0;
         int n;
         int a;
         for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
               g_wd[i] = $urandom;
               g_be[i] = 4'hF;
               mdl[b*8+i] = g_wd[i];
            end
            wr_burst(24'(b*8), 4'd8);
         end
         while (beats < 64) begin
            n = $urandom_range(1, 6);
            a = $urandom_range(0, 32 - n);
            if ($urandom_range(0, 1) == 1) begin
               for (int i = 0; i < n; i++) begin
                  g_wd[i] = $urandom;
                  g_be[i] = 4'($urandom_range(0, 15));
                  for (int b = 0; b < 4; b++)
                     if (g_be[i][b]) mdl[a+i][b*8 +: 8] = g_wd[i][b*8 +: 8];
               end
               wr_burst(24'(a), 4'(n));
            end else begin
               rd_burst(24'(a), 4'(n), $sformatf("rnd@%0d", a));
               for (int i = 0; i < n; i++)
                  check($sformatf("rnd data %0d+%0d", a, i), g_rd[i], mdl[a+i]);
            end
            beats += n;
         end
         check("inject stall seen",  32'(stall_seen), 32'd1);
         check("inject accept seen", 32'(go_seen),    32'd1);
         check("inject no proto_err", 32'(n_perr),    32'd0);
      end
`else
      // ---------------- single-beat table
      vt[0]  = '{1'b1, 24'h000010, 32'hDEADBEEF, 4'hF, 32'h0};
      vt[1]  = '{1'b0, 24'h000010, 32'h0,        4'h0, 32'hDEADBEEF};
      vt[2]  = '{1'b1, 24'h000011, 32'h12345678, 4'hF, 32'h0};
      vt[3]  = '{1'b1, 24'h000011, 32'hAABBCCDD, 4'h5, 32'h0};
      vt[4]  = '{1'b0, 24'h000011, 32'h0,        4'h0, 32'h12BB56DD};
      vt[5]  = '{1'b1, 24'h000012, 32'h00000000, 4'hF, 32'h0};
      vt[6]  = '{1'b1, 24'h000012, 32'hCAFEF00D, 4'h8, 32'h0};
      vt[7]  = '{1'b0, 24'h000012, 32'h0,        4'h0, 32'hCA000000};
      vt[8]  = '{1'b1, 24'hAB0013, 32'h11223344, 4'hF, 32'h0};
      vt[9]  = '{1'b0, 24'h000013, 32'h0,        4'h0, 32'h11223344};
      vt[10] = '{1'b0, 24'h5F0013, 32'h0,        4'h0, 32'h11223344};
      vt[11] = '{1'b1, 24'h000010, 32'hFFFFFFFF, 4'h0, 32'h0};
      vt[12] = '{1'b0, 24'h000010, 32'h0,        4'h0, 32'hDEADBEEF};
      vt[13] = '{1'b0, 24'h000011, 32'h0,        4'h0, 32'h12BB56DD};
      for (int i = 0; i < 14; i++) begin
         if (vt[i].wr) begin
            g_wd[0] = vt[i].data;
            g_be[0] = vt[i].be;
            wr_burst(vt[i].addr, 4'd1);
         end else begin
            rd_burst(vt[i].addr, 4'd1, $sformatf("vec%0d", i));
            check($sformatf("vec%0d data", i), g_rd[0], vt[i].exp);
         end
      end
      check("table proto_err", 32'(n_perr), 32'd0);

      // ---------------- burst N=4, partial byteenable on beat 2
      for (int i = 0; i < 4; i++) begin g_wd[i] = 32'd0; g_be[i] = 4'hF; end
      wr_burst(24'h000020, 4'd4);
      for (int i = 0; i < 4; i++) begin g_wd[i] = 32'(i + 1); g_be[i] = 4'hF; end
      g_be[2] = 4'b0011;
      wr_burst(24'h000020, 4'd4);
      rd_burst(24'h000020, 4'd4, "burst4");
      check("burst4 beat0", g_rd[0], 32'h00000001);
      check("burst4 beat1", g_rd[1], 32'h00000002);
      check("burst4 beat2", g_rd[2], 32'h00000003 & 32'h0000FFFF);
      check("burst4 beat3", g_rd[3], 32'h00000004);

      // ---------------- wrap at the top of the RAM
      for (int i = 0; i < 3; i++) begin g_wd[i] = 32'hA0000000 + 32'(i); g_be[i] = 4'hF; end
      wr_burst(24'h003FFF, 4'd3);
      rd_burst(24'h003FFF, 4'd1, "wrap top");
      check("wrap top data", g_rd[0], 32'hA0000000);
      rd_burst(24'h000000, 4'd1, "wrap idx0");
      check("wrap idx0 data", g_rd[0], 32'hA0000001);
      rd_burst(24'h000001, 4'd1, "wrap idx1");
      check("wrap idx1 data", g_rd[0], 32'hA0000002);
      rd_burst(24'hFF3FFF, 4'd3, "wrap burst");
      for (int i = 0; i < 3; i++)
         check($sformatf("wrap burst beat%0d", i), g_rd[i], 32'hA0000000 + 32'(i));
      check("burst proto_err", 32'(n_perr), 32'd0);

      // ---------------- read and write together in IDLE
      p0 = n_perr;
      s_read       = 1'b1;
      s_write      = 1'b1;
      s_address    = 24'h000030;
      s_writedata  = 32'h55AA55AA;
      s_byteenable = 4'hF;
      s_burstcount = 4'd1;
      check("rw accepted", 32'(s_waitrequest), 32'd0);
      tick();
      idle_inputs();
      cnt = 0;
      wcnt = 0;
      for (int k = 0; k < 8; k++) begin
         if (s_readdatavalid) cnt++;
         if (s_waitrequest) wcnt++;
         tick();
      end
      check("rw no readvalid", 32'(cnt),  32'd0);
      check("rw stays idle",   32'(wcnt), 32'd0);
      check("rw proto_err",    32'(n_perr - p0), 32'd1);
      rd_burst(24'h000030, 4'd1, "rw readback");
      check("rw readback data", g_rd[0], 32'h55AA55AA);

      // ---------------- burstcount 0
      p0 = n_perr;
      g_wd[0] = 32'h0BADF00D;
      g_be[0] = 4'hF;
      wr_burst(24'h000031, 4'd0);
      g_wd[0] = 32'h35353535;
      wr_burst(24'h000035, 4'd1);
      tick();
      tick();
      check("bc0 write proto_err", 32'(n_perr - p0), 32'd1);
      rd_burst(24'h000031, 4'd1, "bc0 rb31");
      check("bc0 rb31 data", g_rd[0], 32'h0BADF00D);
      rd_burst(24'h000035, 4'd1, "bc0 rb35");
      check("bc0 rb35 data", g_rd[0], 32'h35353535);
      p0 = n_perr;
      rd_burst(24'h000031, 4'd0, "bc0 read");
      check("bc0 read data", g_rd[0], 32'h0BADF00D);
      check("bc0 read proto_err", 32'(n_perr - p0), 32'd1);

      // ---------------- reset in the middle of an 8-beat read
      for (int i = 0; i < 8; i++) begin g_wd[i] = 32'h100 + 32'(i); g_be[i] = 4'hF; end
      wr_burst(24'h000040, 4'd8);
      s_read       = 1'b1;
      s_address    = 24'h000040;
      s_burstcount = 4'd8;
      check("rst8 accepted", 32'(s_waitrequest), 32'd0);
      tick();
      idle_inputs();
      cnt = 0;
      guard = 0;
      while (guard < 20) begin
         if (s_readdatavalid) cnt++;
         if (cnt == 2) break;
         tick();
         guard++;
      end
      check("rst8 beats before reset", 32'(cnt), 32'd2);
      check("rst8 beat1 data", s_readdata, 32'h00000101);
      rst_n = 1'b0;
      #1;
      check("rst8 readvalid in reset", 32'(s_readdatavalid), 32'd0);
      check("rst8 readdata in reset",  s_readdata,           32'd0);
      check("rst8 wait in reset",      32'(s_waitrequest),   32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("rst8 wait after release", 32'(s_waitrequest), 32'd0);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         if (s_readdatavalid) cnt++;
         tick();
      end
      check("rst8 no stray beats", 32'(cnt), 32'd0);
      rd_burst(24'h000040, 4'd8, "rst8 readback");
      for (int i = 0; i < 8; i++)
         check($sformatf("rst8 retained %0d", i), g_rd[i], 32'h100 + 32'(i));
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
